// File: rtl/mandel_coord_gen.sv
// Raster-order scan generator for the divergence datapath.
// Walks an H_RES x V_RES pixel grid and emits one complex constant
// c = (c_re, c_im) per pixel over a valid/ready handshake, together with
// pixel indices and first/last markers for the framebuffer writer.
module mandel_coord_gen #(
    parameter int WIDTH = 32,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] x_start,
    input  logic [WIDTH-1:0] y_start,
    input  logic [WIDTH-1:0] x_step,
    input  logic [WIDTH-1:0] y_step,
    output logic             c_valid,
    input  logic             c_ready,
    output logic [WIDTH-1:0] c_re,
    output logic [WIDTH-1:0] c_im,
    output logic [XW-1:0]    px_x,
    output logic [YW-1:0]    px_y,
    output logic             first_px,
    output logic             last_px,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] x_start_q,    x_start_d;
    logic [WIDTH-1:0] y_start_q,    y_start_d;
    logic [WIDTH-1:0] x_step_q,     x_step_d;
    logic [WIDTH-1:0] y_step_q,     y_step_d;
    logic [WIDTH-1:0] c_re_q,       c_re_d;
    logic [WIDTH-1:0] c_im_q,       c_im_d;
    logic [XW-1:0]    px_x_q,       px_x_d;
    logic [YW-1:0]    px_y_q,       px_y_d;
    logic             c_valid_q,    c_valid_d;
    logic             frame_done_q, frame_done_d;

    logic xfer;
    logic row_end;
    logic frame_end;

    assign xfer      = c_valid_q && c_ready;
    assign row_end   = (px_x_q == X_LAST);
    assign frame_end = row_end && (px_y_q == Y_LAST);

    // State register and datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            // NOTE: the latched config is a handful of flops, not a memory
            // array, so it is reset like everything else to give a known
            // state after power-up.
            x_start_q    <= '0;
            y_start_q    <= '0;
            x_step_q     <= '0;
            y_step_q     <= '0;
            c_re_q       <= '0;
            c_im_q       <= '0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            c_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            x_start_q    <= x_start_d;
            y_start_q    <= y_start_d;
            x_step_q     <= x_step_d;
            y_step_q     <= y_step_d;
            c_re_q       <= c_re_d;
            c_im_q       <= c_im_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            c_valid_q    <= c_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: start a frame, advance the raster on transfer, abort.
    always_comb begin
        // NOTE: every next-state value gets a hold default first, so no
        // path through the branches below can infer a latch.
        state_d      = state_q;
        x_start_d    = x_start_q;
        y_start_d    = y_start_q;
        x_step_d     = x_step_q;
        y_step_d     = y_step_q;
        c_re_d       = c_re_q;
        c_im_d       = c_im_q;
        px_x_d       = px_x_q;
        px_y_d       = px_y_q;
        c_valid_d    = c_valid_q;
        frame_done_d = 1'b0;

        if (abort) begin
            // Drop the frame; coordinate and index registers keep their values.
            state_d   = ST_IDLE;
            c_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_start_d = x_start;
                        y_start_d = y_start;
                        x_step_d  = x_step;
                        y_step_d  = y_step;
                        c_re_d    = x_start;
                        c_im_d    = y_start;
                        px_x_d    = '0;
                        px_y_d    = '0;
                        c_valid_d = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (frame_end) begin
                            c_valid_d    = 1'b0;
                            frame_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else if (row_end) begin
                            // Reload the row origin so column rounding
                            // error never carries into the next row.
                            px_x_d = '0;
                            c_re_d = x_start_q;
                            px_y_d = px_y_q + YW'(1);
                            c_im_d = c_im_q + y_step_q;
                        end else begin
                            px_x_d = px_x_q + XW'(1);
                            c_re_d = c_re_q + x_step_q;
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    c_valid_d = 1'b0;
                end
            endcase
        end
    end

    assign c_valid    = c_valid_q;
    assign c_re       = c_re_q;
    assign c_im       = c_im_q;
    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign busy       = (state_q == ST_RUN);
    assign frame_done = frame_done_q;
    // Markers are decoded from the indices and gated so they read 0 when idle.
    assign first_px   = c_valid_q && (px_x_q == '0) && (px_y_q == '0);
    assign last_px    = c_valid_q && frame_end;

endmodule

// File: doc/mandel_coord_gen.md
Name: mandel_coord_gen

Overview:
- Upstream scan stage for the divergence datapath. Walks a rectangular pixel grid in raster order and emits one complex constant c = (c_re, c_im) per pixel.
- c is in the same 32-bit two's-complement fixed-point format that the divergence/iteration stage consumes on its a/b inputs.
- Uses a valid/ready handshake, so a multi-cycle iteration stage can throttle the scan.
- Emits pixel indices and frame markers for the framebuffer writer further downstream.

Parameters:
- WIDTH, 32, bit width of fixed-point coordinates and steps.
- H_RES, 640, pixels per row (>=2).
- V_RES, 480, rows per frame (>=2).
- XW, 10, width of px_x (>= clog2(H_RES)).
- YW, 9, width of px_y (>= clog2(V_RES)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- abort  input  1  cancel the current frame.
- x_start  input  WIDTH  real part of the top-left pixel; latched on start.
- y_start  input  WIDTH  imaginary part of the top-left pixel; latched on start.
- x_step  input  WIDTH  per-column increment of c_re; latched on start.
- y_step  input  WIDTH  per-row increment of c_im (negative values allowed); latched on start.
- c_valid  output  1  c_re/c_im/px_x/px_y/first_px/last_px are valid.
- c_ready  input  1  downstream accepts the current beat.
- c_re  output  WIDTH  real part of c.
- c_im  output  WIDTH  imaginary part of c.
- px_x  output  XW  column index.
- px_y  output  YW  row index.
- first_px  output  1  beat is pixel (0,0).
- last_px  output  1  beat is pixel (H_RES-1, V_RES-1).
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the last pixel transfers.

Behaviour:
- Reset (async assert, outputs go low immediately): state IDLE; c_valid, busy, frame_done, first_px and last_px = 0; c_re, c_im, px_x, px_y = 0; latched config = 0.
- State IDLE:
  - busy=0, c_valid=0.
  - start=1 → latch x_start/y_start/x_step/y_step.
  - Next cycle: c_re=x_start, c_im=y_start, px_x=0, px_y=0, c_valid=1, busy=1, state RUN.
  - Latency start→c_valid is 1 cycle.
- State RUN:
  - A transfer is a cycle with c_valid && c_ready.
  - While c_valid && !c_ready, all output data and flags hold stable. c_valid never drops without a transfer, except on abort or reset.
  - On transfer, non-final pixel, px_x < H_RES-1: px_x+1, c_re += x_step. c_im and px_y unchanged.
  - On transfer, non-final pixel, px_x == H_RES-1: px_x=0, c_re = latched x_start (reloaded, not accumulated backwards), px_y+1, c_im += y_step.
  - The next beat is presented the following cycle with c_valid held high. This gives back-to-back throughput of 1 pixel/cycle when c_ready stays high.
  - On transfer of the final pixel: c_valid=0 next cycle, frame_done=1 for exactly one cycle, busy=0, state IDLE.
  - start during RUN is ignored; it does not re-latch config.
- first_px = (px_x==0 && px_y==0) while c_valid. last_px = (px_x==H_RES-1 && px_y==V_RES-1) while c_valid. Both are 0 when c_valid=0.
- Arithmetic:
  - WIDTH-bit two's-complement add, wrapping modulo 2^WIDTH, no saturation or overflow flag.
  - Row reload means column accumulation error never carries across rows.
  - c_im accumulates V_RES-1 times per frame.
- abort:
  - Highest priority after rst.
  - In any state, next cycle: c_valid=0, busy=0, state IDLE. frame_done is not pulsed. px/c registers hold their last values.
  - A transfer in the abort cycle is discarded for sequencing purposes.
  - start and abort asserted together in IDLE: abort wins, no frame starts.
- start asserted in the same cycle frame_done pulses (state already IDLE): accepted, so a new frame begins with no gap cycle.
- Reset mid-frame: immediate return to reset values; no frame_done.

Test Plan (H_RES=4, V_RES=3, WIDTH=32 unless stated):
- rst then start with x_start=0xFE000000, y_start=0x01000000, x_step=0x00400000, y_step=0xFFC00000, c_ready=1 → 12 beats on consecutive cycles. Beat0 = (0xFE000000, 0x01000000) with first_px=1. Beat3 c_re=0xFEC00000. Beat4 = (0xFE000000, 0x00C00000, px_y=1). Beat11 c_im=0x00800000 with last_px=1. frame_done pulses one cycle after beat11.
- Same frame with c_ready toggling 1,0,0,1,… → each beat held unchanged while c_ready=0; beat sequence identical to the previous test; no beat skipped or duplicated.
- abort asserted while presenting beat 5 with c_ready=1 → c_valid=0 and busy=0 next cycle, no frame_done. A subsequent start restarts at (0,0) with the newly latched config.
- start pulsed during RUN with different x_start → ignored; the frame completes using the original config.
- x_start=0x7FFFFFFF, x_step=1 → beat1 c_re=0x80000000 (wrap); row 1 reloads 0x7FFFFFFF.
- Async rst asserted between clock edges mid-frame → c_valid/busy go 0 immediately, before the next clk edge. start after deassert begins a clean frame.
